// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file scoreboard slice.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and address width.
//   busy_state_e                    : per-register busy state (IDLE / PENDING).
package reg_file_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_ADDR_W = 2;

  typedef enum logic {
    BUSY_IDLE    = 1'b0,
    BUSY_PENDING = 1'b1
  } busy_state_e;

endpackage

// File: rtl/busy_scoreboard.sv
// Per-register busy tracking for the register file.
// A register goes PENDING when a producer reserves it and returns to IDLE when
// its result is written back.
//   CLK, RST_N                    : clock, synchronous active-low reset.
//   WriteControl, WriteAddress    : write-back that retires a pending register.
//   ReserveControl, ReserveAddress: reservation request.
//   ReserveOK                     : reservation at ReserveAddress accepted now.
//   BusyVector                    : busy bit per register (zero while in reset).
module busy_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned DEPTH   = 2 ** ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WriteControl,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic              ReserveControl,
  input  logic [ADDR_W-1:0] ReserveAddress,
  output logic              ReserveOK,
  output logic [DEPTH-1:0]  BusyVector
);

  busy_state_e      state [DEPTH];
  logic [DEPTH-1:0] busyRaw;
  logic             reserveTake;

  always_comb begin
    busyRaw = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busyRaw[i] = (state[i] == BUSY_PENDING);
    end
  end

  // Masked while reset is held so nothing reports stale reservations before
  // the reset edge has cleared the state.
  assign BusyVector = RST_N ? busyRaw : '0;

  // A same-cycle write frees the register, so a new producer may claim it.
  assign ReserveOK   = ~BusyVector[ReserveAddress] |
                       (WriteControl && (WriteAddress == ReserveAddress));
  assign reserveTake = ReserveControl && ReserveOK;

  // Reserve has priority over write-back on the same register: the new
  // producer's result is still outstanding.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!RST_N || (ZERO_REG && (i == 0))) begin
        state[i] <= BUSY_IDLE;
      end else if (reserveTake && (ReserveAddress == ADDR_W'(i))) begin
        state[i] <= BUSY_PENDING;
      end else if (WriteControl && (WriteAddress == ADDR_W'(i))) begin
        state[i] <= BUSY_IDLE;
      end
    end
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// Two-read, one-write register file with a busy scoreboard.
//   CLK, RST_N                       : clock, synchronous active-low reset.
//   ReadAddress1/2                   : read port addresses.
//   ReadValue1/2                     : combinational read data (optionally bypassed).
//   ReadBusy1/2                      : register at the read address awaits a write.
//   WriteControl/Address/Value       : write port.
//   ReserveControl/Address, ReserveOK: reservation request and acceptance.
//   BusyVector                       : busy bit per register.
// ZERO_REG=1 hardwires register 0 to zero; BYPASS=1 forwards same-cycle write
// data (and clears the busy flag) on matching read ports.
module register_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned DEPTH   = 2 ** ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] ReadAddress1,
  output logic [DATA_W-1:0] ReadValue1,
  output logic              ReadBusy1,
  input  logic [ADDR_W-1:0] ReadAddress2,
  output logic [DATA_W-1:0] ReadValue2,
  output logic              ReadBusy2,
  input  logic              WriteControl,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteValue,
  input  logic              ReserveControl,
  input  logic [ADDR_W-1:0] ReserveAddress,
  output logic              ReserveOK,
  output logic [DEPTH-1:0]  BusyVector
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] rdAddr [2];
  logic [DATA_W-1:0] rdData [2];
  logic              rdBusy [2];

  busy_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .WriteControl   (WriteControl),
    .WriteAddress   (WriteAddress),
    .ReserveControl (ReserveControl),
    .ReserveAddress (ReserveAddress),
    .ReserveOK      (ReserveOK),
    .BusyVector     (BusyVector)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (WriteControl && !(ZERO_REG && (WriteAddress == '0))) begin
      regs[WriteAddress] <= WriteValue;
    end
  end

  assign rdAddr[0] = ReadAddress1;
  assign rdAddr[1] = ReadAddress2;

  // Both ports share one read path so they always agree on the same address.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rdData[p] = regs[rdAddr[p]];
      rdBusy[p] = BusyVector[rdAddr[p]];
      if (BYPASS && WriteControl && (WriteAddress == rdAddr[p])) begin
        rdData[p] = WriteValue;
        rdBusy[p] = 1'b0;
      end
      if (ZERO_REG && (rdAddr[p] == '0)) begin
        rdData[p] = '0;
      end
      if (!RST_N) begin
        rdData[p] = '0;
        rdBusy[p] = 1'b0;
      end
    end
  end

  assign ReadValue1 = rdData[0];
  assign ReadBusy1  = rdBusy[0];
  assign ReadValue2 = rdData[1];
  assign ReadBusy2  = rdBusy[1];

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: a default instance (BYPASS=1),
// a ZERO_REG=1/BYPASS=0 instance sharing its stimulus, and a 16x8 instance.
module tb_register_file_scoreboard;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  // Stimulus shared by the default and zero-register instances.
  logic       WriteControl, ReserveControl;
  logic [1:0] WriteAddress, ReserveAddress, ReadAddress1, ReadAddress2;
  logic [7:0] WriteValue;

  logic [7:0] rv1, rv2, zrv1, zrv2;
  logic       rb1, rb2, rok, zrb1, zrb2, zrok;
  logic [3:0] bv, zbv;

  // Wide instance stimulus/outputs.
  logic        wWC, wRC;
  logic [2:0]  wWA, wRA, wRA1, wRA2;
  logic [15:0] wWV, wrv1, wrv2;
  logic        wrb1, wrb2, wrok;
  logic [7:0]  wbv;

  int errors = 0;
  int checks = 0;

  register_file_scoreboard dut (
    .CLK(CLK), .RST_N(RST_N),
    .ReadAddress1(ReadAddress1), .ReadValue1(rv1), .ReadBusy1(rb1),
    .ReadAddress2(ReadAddress2), .ReadValue2(rv2), .ReadBusy2(rb2),
    .WriteControl(WriteControl), .WriteAddress(WriteAddress), .WriteValue(WriteValue),
    .ReserveControl(ReserveControl), .ReserveAddress(ReserveAddress),
    .ReserveOK(rok), .BusyVector(bv)
  );

  register_file_scoreboard #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dutZ (
    .CLK(CLK), .RST_N(RST_N),
    .ReadAddress1(ReadAddress1), .ReadValue1(zrv1), .ReadBusy1(zrb1),
    .ReadAddress2(ReadAddress2), .ReadValue2(zrv2), .ReadBusy2(zrb2),
    .WriteControl(WriteControl), .WriteAddress(WriteAddress), .WriteValue(WriteValue),
    .ReserveControl(ReserveControl), .ReserveAddress(ReserveAddress),
    .ReserveOK(zrok), .BusyVector(zbv)
  );

  register_file_scoreboard #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1)) dutW (
    .CLK(CLK), .RST_N(RST_N),
    .ReadAddress1(wRA1), .ReadValue1(wrv1), .ReadBusy1(wrb1),
    .ReadAddress2(wRA2), .ReadValue2(wrv2), .ReadBusy2(wrb2),
    .WriteControl(wWC), .WriteAddress(wWA), .WriteValue(wWV),
    .ReserveControl(wRC), .ReserveAddress(wRA),
    .ReserveOK(wrok), .BusyVector(wbv)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ctl();
    WriteControl = 1'b0; ReserveControl = 1'b0;
    wWC = 1'b0; wRC = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    clear_ctl();
    WriteAddress = 2'd0; WriteValue = 8'h00; ReserveAddress = 2'd0;
    ReadAddress1 = 2'd0; ReadAddress2 = 2'd3;
    wWA = 3'd0; wWV = 16'h0; wRA = 3'd0; wRA1 = 3'd0; wRA2 = 3'd0;
    step();
    #1;
    checks++; if (rv1 !== 8'h00) begin errors++; $display("FAIL reset_rv1 got=%h exp=00", rv1); end
    checks++; if (rv2 !== 8'h00) begin errors++; $display("FAIL reset_rv2 got=%h exp=00", rv2); end
    checks++; if (bv !== 4'b0000) begin errors++; $display("FAIL reset_bv got=%b exp=0000", bv); end
    checks++; if (rb1 !== 1'b0 || rb2 !== 1'b0) begin errors++; $display("FAIL reset_rb got=%b%b exp=00", rb1, rb2); end
    checks++; if (rok !== 1'b1) begin errors++; $display("FAIL reset_rok got=%b exp=1", rok); end
    checks++; if (wbv !== 8'h00) begin errors++; $display("FAIL reset_wbv got=%b exp=00000000", wbv); end
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_write_bypass();
    WriteControl = 1'b1; WriteAddress = 2'd2; WriteValue = 8'hA5; ReadAddress1 = 2'd2;
    #1;
    checks++; if (rv1 !== 8'hA5) begin errors++; $display("FAIL bypass_pre got=%h exp=a5", rv1); end
    checks++; if (zrv1 !== 8'h00) begin errors++; $display("FAIL nobypass_pre got=%h exp=00", zrv1); end
    step();
    clear_ctl();
    #1;
    checks++; if (rv1 !== 8'hA5) begin errors++; $display("FAIL bypass_post got=%h exp=a5", rv1); end
    checks++; if (zrv1 !== 8'hA5) begin errors++; $display("FAIL nobypass_post got=%h exp=a5", zrv1); end
  endtask

  task automatic test_reserve();
    ReserveControl = 1'b1; ReserveAddress = 2'd1; ReadAddress2 = 2'd1;
    #1;
    checks++; if (rok !== 1'b1) begin errors++; $display("FAIL rsv_first_ok got=%b exp=1", rok); end
    step();
    #1;
    checks++; if (rok !== 1'b0) begin errors++; $display("FAIL rsv_second_ok got=%b exp=0", rok); end
    checks++; if (bv !== 4'b0010) begin errors++; $display("FAIL rsv_bv got=%b exp=0010", bv); end
    checks++; if (rb2 !== 1'b1) begin errors++; $display("FAIL rsv_rb2 got=%b exp=1", rb2); end
    step();
    clear_ctl();
    #1;
    checks++; if (bv !== 4'b0010) begin errors++; $display("FAIL rsv_ignored_bv got=%b exp=0010", bv); end
    WriteControl = 1'b1; WriteAddress = 2'd1; WriteValue = 8'h3C;
    #1;
    checks++; if (rb2 !== 1'b0 || rv2 !== 8'h3C) begin errors++; $display("FAIL rsv_fwd got=%b/%h exp=0/3c", rb2, rv2); end
    checks++; if (zrb2 !== 1'b1 || zrv2 !== 8'h00) begin errors++; $display("FAIL rsv_nofwd got=%b/%h exp=1/00", zrb2, zrv2); end
    step();
    clear_ctl();
    #1;
    checks++; if (bv !== 4'b0000 || zbv !== 4'b0000) begin errors++; $display("FAIL rsv_retire got=%b/%b exp=0000", bv, zbv); end
    checks++; if (rv2 !== 8'h3C) begin errors++; $display("FAIL rsv_value got=%h exp=3c", rv2); end
  endtask

  task automatic test_write_reserve_same();
    ReserveControl = 1'b1; ReserveAddress = 2'd3;
    step();
    clear_ctl();
    #1;
    checks++; if (bv !== 4'b1000) begin errors++; $display("FAIL wrs_pend got=%b exp=1000", bv); end
    WriteControl = 1'b1; WriteAddress = 2'd3; WriteValue = 8'h11;
    ReserveControl = 1'b1; ReserveAddress = 2'd3;
    #1;
    checks++; if (rok !== 1'b1) begin errors++; $display("FAIL wrs_ok got=%b exp=1", rok); end
    step();
    clear_ctl();
    ReadAddress1 = 2'd3;
    #1;
    checks++; if (rv1 !== 8'h11) begin errors++; $display("FAIL wrs_value got=%h exp=11", rv1); end
    checks++; if (bv !== 4'b1000 || rb1 !== 1'b1) begin errors++; $display("FAIL wrs_busy got=%b/%b exp=1000/1", bv, rb1); end
  endtask

  task automatic test_zero_reg();
    WriteControl = 1'b1; WriteAddress = 2'd0; WriteValue = 8'hFF;
    ReserveControl = 1'b1; ReserveAddress = 2'd0; ReadAddress1 = 2'd0;
    #1;
    checks++; if (zrok !== 1'b1) begin errors++; $display("FAIL zero_ok got=%b exp=1", zrok); end
    checks++; if (zrv1 !== 8'h00) begin errors++; $display("FAIL zero_pre got=%h exp=00", zrv1); end
    checks++; if (rv1 !== 8'hFF) begin errors++; $display("FAIL nz_pre got=%h exp=ff", rv1); end
    step();
    clear_ctl();
    #1;
    checks++; if (zrv1 !== 8'h00) begin errors++; $display("FAIL zero_post got=%h exp=00", zrv1); end
    checks++; if (zbv !== 4'b1000) begin errors++; $display("FAIL zero_bv got=%b exp=1000", zbv); end
    checks++; if (bv !== 4'b1001 || rv1 !== 8'hFF) begin errors++; $display("FAIL nz_post got=%b/%h exp=1001/ff", bv, rv1); end
  endtask

  task automatic test_reset_pending();
    logic [7:0] vals [4];
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h04;
    for (int i = 0; i < 4; i++) begin
      WriteControl = 1'b1; WriteAddress = 2'(i); WriteValue = vals[i];
      step();
    end
    clear_ctl();
    ReserveControl = 1'b1; ReserveAddress = 2'd1;
    step();
    ReserveAddress = 2'd2;
    step();
    clear_ctl();
    ReadAddress1 = 2'd3;
    #1;
    checks++; if (bv !== 4'b0110 || rv1 !== 8'h04) begin errors++; $display("FAIL rp_setup got=%b/%h exp=0110/04", bv, rv1); end
    RST_N = 1'b0;
    WriteControl = 1'b1; WriteAddress = 2'd2; WriteValue = 8'h77; ReadAddress1 = 2'd2;
    #1;
    checks++; if (rv1 !== 8'h00 || bv !== 4'b0000) begin errors++; $display("FAIL rp_during got=%h/%b exp=00/0000", rv1, bv); end
    step();
    RST_N = 1'b1;
    clear_ctl();
    for (int a = 0; a < 4; a++) begin
      ReadAddress1 = 2'(a); ReadAddress2 = 2'(a);
      #1;
      checks++;
      if (rv1 !== 8'h00 || rv2 !== 8'h00) begin errors++; $display("FAIL rp_read%0d got=%h/%h exp=00/00", a, rv1, rv2); end
    end
    checks++; if (bv !== 4'b0000) begin errors++; $display("FAIL rp_bv got=%b exp=0000", bv); end
    WriteControl = 1'b1; WriteAddress = 2'd2; WriteValue = 8'h55; ReadAddress1 = 2'd2;
    step();
    clear_ctl();
    #1;
    checks++; if (bv !== 4'b0000 || rv1 !== 8'h55) begin errors++; $display("FAIL rp_after got=%b/%h exp=0000/55", bv, rv1); end
  endtask

  task automatic test_wide();
    wRC = 1'b1; wRA = 3'd7;
    step();
    clear_ctl();
    wRA1 = 3'd7; wRA2 = 3'd7;
    #1;
    checks++; if (wbv !== 8'h80 || wrb1 !== 1'b1) begin errors++; $display("FAIL wide_pend got=%b/%b exp=10000000/1", wbv, wrb1); end
    wWC = 1'b1; wWA = 3'd7; wWV = 16'hBEEF;
    #1;
    checks++; if (wrv1 !== 16'hBEEF || wrv2 !== 16'hBEEF) begin errors++; $display("FAIL wide_fwd got=%h/%h exp=beef", wrv1, wrv2); end
    checks++; if (wrb1 !== 1'b0 || wrb2 !== 1'b0) begin errors++; $display("FAIL wide_busy got=%b%b exp=00", wrb1, wrb2); end
    step();
    clear_ctl();
    #1;
    checks++; if (wbv !== 8'h00 || wrv1 !== 16'hBEEF || wrv2 !== 16'hBEEF) begin errors++; $display("FAIL wide_post got=%b/%h/%h exp=0/beef/beef", wbv, wrv1, wrv2); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_reserve();
    test_write_reserve_same();
    test_zero_reg();
    test_reset_pending();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
